ccip_tx_flow_scheduler: RTL and testbench

Arbitration and sequencing controller for the CCI-P tx path. It watches per-flow FIFO occupancy and picks, round-robin, the next flow allowed to emit a batched eREQ_WRLINE_I burst. It flushes partial batches after a configurable idle timeout and gates new grants on CCI-P c1 almost-full. It sits between the flow FIFOs and the transmit engine, replacing the engine's internal linear flow poll.

---
 rtl/nic_defs.sv | 33 +++
 rtl/rr_priority_select.sv | 43 ++++
 rtl/ccip_tx_flow_scheduler.sv | 142 ++++++++++++++
 tb/tb_ccip_tx_flow_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nic_defs.sv
// Shared constants, types and helpers for the CCI-P tx flow scheduler.
package nic_defs;

  localparam int unsigned LMAX_CCIP_BATCH = 2;
  localparam int unsigned NL_W            = LMAX_CCIP_BATCH + 1;

  typedef enum logic [1:0] {
    SIdle,
    SScan,
    SOffer,
    SBusy
  } sched_state_t;

  // log2 batch size -> line count; encodings above 2 saturate at 4 lines
  function automatic logic [NL_W-1:0] batch_lines(input logic [LMAX_CCIP_BATCH-1:0] l_size);
    case (l_size)
      LMAX_CCIP_BATCH'(0): return NL_W'(1);
      LMAX_CCIP_BATCH'(1): return NL_W'(2);
      default:             return NL_W'(4);
    endcase
  endfunction

  // Largest power of two not exceeding min(occ, batch)
  function automatic logic [NL_W-1:0] flush_lines(input int unsigned occ,
                                                  input logic [NL_W-1:0] batch);
    int unsigned m;
    m = (occ < 32'(batch)) ? occ : 32'(batch);
    if (m >= 32'd4)      return NL_W'(4);
    else if (m >= 32'd2) return NL_W'(2);
    else                 return NL_W'(1);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating priority search over requests 0..limit, starting just after ptr.
module rr_priority_select #(
  parameter int unsigned W = 1
) (
  input  logic [2**W-1:0] req,
  input  logic [W-1:0]    ptr,
  input  logic [W-1:0]    limit,
  output logic [W-1:0]    winner,
  output logic            valid
);

  localparam int unsigned N = 2**W;

  logic [W-1:0] first;
  logic [N-1:0] lim_mask;
  logic [N-1:0] from_mask;
  logic [N-1:0] req_lim;
  logic [N-1:0] req_hi;
  logic [N-1:0] pick;
  logic [N-1:0] onehot;

  // Pointer at or past the limit wraps the search back to flow 0
  assign first = (ptr >= limit) ? '0 : ptr + W'(1);

  always_comb begin
    lim_mask  = '0;
    from_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      lim_mask[i]  = (W'(i) <= limit);
      from_mask[i] = (W'(i) >= first);
    end
    req_lim = req & lim_mask;
    req_hi  = req_lim & from_mask;
    pick    = (|req_hi) ? req_hi : req_lim;
    onehot  = pick & (~pick + N'(1));
    winner  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot[i]) winner = winner | W'(i);
    end
    valid = |req_lim;
  end

endmodule

// File: rtl/ccip_tx_flow_scheduler.sv
// Round-robin selector of the next flow allowed to emit a batched WRLINE_I burst,
// with idle-timeout flushing of partial batches and c1 almost-full gating.
module ccip_tx_flow_scheduler
  import nic_defs::*;
#(
  parameter int          NIC_ID            = 0,
  parameter int unsigned LMAX_NUM_OF_FLOWS = 1,
  parameter int unsigned LTX_FIFO_DEPTH    = 3,
  parameter int unsigned LTIMEOUT          = 16
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   start,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]                           number_of_flows,
  input  logic [LMAX_CCIP_BATCH-1:0]                             l_tx_batch_size,
  input  logic [LTIMEOUT-1:0]                                    flush_timeout,
  input  logic [(2**LMAX_NUM_OF_FLOWS)*(LTX_FIFO_DEPTH+1)-1:0]   flow_occ,
  input  logic                                                   sRx_c1TxAlmFull,
  output logic                                                   grant_valid,
  input  logic                                                   grant_ready,
  output logic [LMAX_NUM_OF_FLOWS-1:0]                           grant_flow_id,
  output logic [LMAX_CCIP_BATCH:0]                               grant_num_lines,
  output logic                                                   grant_flush,
  input  logic                                                   tx_done,
  output logic [31:0]                                            flush_cnt_out
);

  localparam int unsigned MAX_FLOWS = 2**LMAX_NUM_OF_FLOWS;
  localparam int unsigned OCC_W     = LTX_FIFO_DEPTH + 1;
  localparam int unsigned FW        = LMAX_NUM_OF_FLOWS;

  if (LMAX_NUM_OF_FLOWS < 1 || LTIMEOUT < 1 || NIC_ID < 0) begin : g_param_check
    $error("ccip_tx_flow_scheduler NIC %0d: unsupported parameters", NIC_ID);
  end

  sched_state_t      state;
  logic [FW-1:0]     rr_ptr;
  logic [OCC_W-1:0]  occ [MAX_FLOWS];
  logic [LTIMEOUT-1:0] age [MAX_FLOWS];
  logic [MAX_FLOWS-1:0] active;
  logic [MAX_FLOWS-1:0] req_full;
  logic [MAX_FLOWS-1:0] req_flush;
  logic [NL_W-1:0]   batch;
  logic [NL_W-1:0]   flush_len;
  logic [FW-1:0]     full_idx;
  logic [FW-1:0]     flush_idx;
  logic              full_valid;
  logic              flush_valid;
  logic              accept;

  assign batch  = batch_lines(l_tx_batch_size);
  assign accept = (state == SOffer) && grant_ready;

  // Per-flow eligibility for a full batch or a timeout flush
  always_comb begin
    for (int unsigned i = 0; i < MAX_FLOWS; i++) begin
      occ[i]       = flow_occ[i*OCC_W +: OCC_W];
      active[i]    = (FW'(i) <= number_of_flows);
      req_full[i]  = active[i] && (32'(occ[i]) >= 32'(batch));
      req_flush[i] = active[i] && (occ[i] != '0) && (flush_timeout != '0) &&
                     (age[i] >= flush_timeout);
    end
  end

  rr_priority_select #(.W(FW)) u_full_sel (
    .req    (req_full),
    .ptr    (rr_ptr),
    .limit  (number_of_flows),
    .winner (full_idx),
    .valid  (full_valid)
  );

  rr_priority_select #(.W(FW)) u_flush_sel (
    .req    (req_flush),
    .ptr    (rr_ptr),
    .limit  (number_of_flows),
    .winner (flush_idx),
    .valid  (flush_valid)
  );

  assign flush_len = flush_lines(32'(occ[flush_idx]), batch);

  // Idle age per flow; inactive or empty flows and just-granted flows restart at 0
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < MAX_FLOWS; i++) begin
      if (reset || !active[i] || (occ[i] == '0) || (accept && (grant_flow_id == FW'(i)))) begin
        age[i] <= '0;
      end else if (age[i] != '1) begin
        age[i] <= age[i] + LTIMEOUT'(1);
      end
    end
  end

  // Scheduler FSM with registered grant outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= SIdle;
      rr_ptr          <= FW'(MAX_FLOWS - 1);
      grant_valid     <= 1'b0;
      grant_flow_id   <= '0;
      grant_num_lines <= NL_W'(1);
      grant_flush     <= 1'b0;
      flush_cnt_out   <= '0;
    end else begin
      case (state)
        SIdle: begin
          if (start) state <= SScan;
        end
        SScan: begin
          if (!start) begin
            state <= SIdle;
          end else if (!sRx_c1TxAlmFull && (full_valid || flush_valid)) begin
            state       <= SOffer;
            grant_valid <= 1'b1;
            if (full_valid) begin
              grant_flow_id   <= full_idx;
              grant_num_lines <= batch;
              grant_flush     <= 1'b0;
            end else begin
              grant_flow_id   <= flush_idx;
              grant_num_lines <= flush_len;
              grant_flush     <= 1'b1;
            end
          end
        end
        SOffer: begin
          if (grant_ready) begin
            state       <= SBusy;
            grant_valid <= 1'b0;
            rr_ptr      <= grant_flow_id;
            if (grant_flush && (flush_cnt_out != '1)) flush_cnt_out <= flush_cnt_out + 32'd1;
          end
        end
        SBusy: begin
          if (tx_done) state <= SScan;
        end
        default: state <= SIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ccip_tx_flow_scheduler.sv
// Directed self-checking bench for ccip_tx_flow_scheduler (2 flows, 4-bit occupancy).
module tb_ccip_tx_flow_scheduler;

  logic        clk;
  logic        reset;
  logic        start;
  logic [0:0]  number_of_flows;
  logic [1:0]  l_tx_batch_size;
  logic [15:0] flush_timeout;
  logic [7:0]  flow_occ;
  logic        sRx_c1TxAlmFull;
  logic        grant_valid;
  logic        grant_ready;
  logic [0:0]  grant_flow_id;
  logic [2:0]  grant_num_lines;
  logic        grant_flush;
  logic        tx_done;
  logic [31:0] flush_cnt_out;

  int vectors;
  int miscompares;

  ccip_tx_flow_scheduler #(
    .NIC_ID            (0),
    .LMAX_NUM_OF_FLOWS (1),
    .LTX_FIFO_DEPTH    (3),
    .LTIMEOUT          (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .number_of_flows (number_of_flows),
    .l_tx_batch_size (l_tx_batch_size),
    .flush_timeout   (flush_timeout),
    .flow_occ        (flow_occ),
    .sRx_c1TxAlmFull (sRx_c1TxAlmFull),
    .grant_valid     (grant_valid),
    .grant_ready     (grant_ready),
    .grant_flow_id   (grant_flow_id),
    .grant_num_lines (grant_num_lines),
    .grant_flush     (grant_flush),
    .tx_done         (tx_done),
    .flush_cnt_out   (flush_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_occ(input int o1, input int o0);
    flow_occ = {4'(o1), 4'(o0)};
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    start       = 1'b0;
    grant_ready = 1'b0;
    tx_done     = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts clock edges until grant_valid rises, bounded by max
  task automatic wait_grant(input int max, output int cycles);
    cycles = 0;
    while (grant_valid !== 1'b1 && cycles < max) begin
      @(negedge clk);
      cycles++;
    end
    check("grant_seen", 32'(grant_valid), 32'd1);
  endtask

  task automatic accept();
    grant_ready = 1'b1;
    @(negedge clk);
    grant_ready = 1'b0;
  endtask

  task automatic finish_tx();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  int cyc;
  logic seen;

  initial begin
    vectors         = 0;
    miscompares     = 0;
    start           = 1'b0;
    number_of_flows = 1'b1;
    l_tx_batch_size = 2'd2;
    flush_timeout   = 16'd0;
    flow_occ        = 8'h00;
    sRx_c1TxAlmFull = 1'b0;
    grant_ready     = 1'b0;
    tx_done         = 1'b0;
    reset           = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    do_reset();
    check("rst_valid", 32'(grant_valid), 32'd0);
    check("rst_flow", 32'(grant_flow_id), 32'd0);
    check("rst_lines", 32'(grant_num_lines), 32'd1);
    check("rst_flush", 32'(grant_flush), 32'd0);
    check("rst_flush_cnt", flush_cnt_out, 32'd0);

    // Round robin between two full flows, batch 4
    number_of_flows = 1'b1;
    l_tx_batch_size = 2'd2;
    flush_timeout   = 16'd0;
    set_occ(4, 4);
    start = 1'b1;
    wait_grant(20, cyc);
    check("rr_start_lat", 32'(cyc), 32'd2);
    check("rr_g0_flow", 32'(grant_flow_id), 32'd0);
    check("rr_g0_lines", 32'(grant_num_lines), 32'd4);
    check("rr_g0_flush", 32'(grant_flush), 32'd0);
    accept();
    check("rr_busy_valid", 32'(grant_valid), 32'd0);
    finish_tx();
    wait_grant(20, cyc);
    check("rr_done_lat", 32'(cyc), 32'd1);
    check("rr_g1_flow", 32'(grant_flow_id), 32'd1);
    check("rr_g1_lines", 32'(grant_num_lines), 32'd4);
    accept();
    finish_tx();
    wait_grant(20, cyc);
    check("rr_g2_flow", 32'(grant_flow_id), 32'd0);
    check("rr_g2_flush", 32'(grant_flush), 32'd0);

    // Almost-full gating, then a held offer that must stay stable
    do_reset();
    number_of_flows = 1'b1;
    l_tx_batch_size = 2'd2;
    flush_timeout   = 16'd0;
    set_occ(0, 4);
    sRx_c1TxAlmFull = 1'b1;
    start = 1'b1;
    seen  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | grant_valid;
    end
    check("almfull_block", 32'(seen), 32'd0);
    sRx_c1TxAlmFull = 1'b0;
    wait_grant(20, cyc);
    check("almfull_release_lat", 32'(cyc), 32'd1);
    sRx_c1TxAlmFull = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_occ(i % 16, (i + 5) % 16);
      @(negedge clk);
      check("offer_stable", 32'({grant_valid, grant_flush, grant_num_lines, grant_flow_id}),
            32'({1'b1, 1'b0, 3'd4, 1'b0}));
    end
    accept();
    sRx_c1TxAlmFull = 1'b0;
    finish_tx();

    // Flows above number_of_flows are never granted
    do_reset();
    number_of_flows = 1'b0;
    l_tx_batch_size = 2'd2;
    flush_timeout   = 16'd3;
    set_occ(8, 0);
    start = 1'b1;
    seen  = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | grant_valid;
    end
    check("inactive_flow", 32'(seen), 32'd0);

    // Timeout 0 disables flushing; enabling it flushes 2 of 3 lines
    do_reset();
    number_of_flows = 1'b1;
    l_tx_batch_size = 2'd2;
    flush_timeout   = 16'd0;
    set_occ(0, 3);
    start = 1'b1;
    seen  = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | grant_valid;
    end
    check("timeout0_noflush", 32'(seen), 32'd0);
    flush_timeout = 16'd5;
    wait_grant(20, cyc);
    check("flush3_lat", 32'(cyc), 32'd1);
    check("flush3_lines", 32'(grant_num_lines), 32'd2);
    check("flush3_flag", 32'(grant_flush), 32'd1);

    // Batch 2 full grant, then idle flush of the remaining line
    do_reset();
    number_of_flows = 1'b1;
    l_tx_batch_size = 2'd1;
    flush_timeout   = 16'd10;
    set_occ(3, 0);
    start = 1'b1;
    wait_grant(20, cyc);
    check("b2_lat", 32'(cyc), 32'd2);
    check("b2_flow", 32'(grant_flow_id), 32'd1);
    check("b2_lines", 32'(grant_num_lines), 32'd2);
    check("b2_flush", 32'(grant_flush), 32'd0);
    accept();
    set_occ(1, 0);
    finish_tx();
    wait_grant(40, cyc);
    check("idle_flush_delay", 32'(cyc), 32'd10);
    check("idle_flush_flow", 32'(grant_flow_id), 32'd1);
    check("idle_flush_lines", 32'(grant_num_lines), 32'd1);
    check("idle_flush_flag", 32'(grant_flush), 32'd1);
    check("idle_flush_cnt_pre", flush_cnt_out, 32'd0);
    accept();
    check("idle_flush_cnt", flush_cnt_out, 32'd1);

    // Reset while busy: outputs and round-robin pointer return to reset state
    l_tx_batch_size = 2'd2;
    set_occ(4, 4);
    finish_tx();
    wait_grant(20, cyc);
    check("pre_rst_flow", 32'(grant_flow_id), 32'd0);
    accept();
    check("pre_rst_cnt", flush_cnt_out, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("busy_rst_valid", 32'(grant_valid), 32'd0);
    check("busy_rst_cnt", flush_cnt_out, 32'd0);
    check("busy_rst_lines", 32'(grant_num_lines), 32'd1);
    reset = 1'b0;
    wait_grant(20, cyc);
    check("post_rst_lat", 32'(cyc), 32'd2);
    check("post_rst_flow", 32'(grant_flow_id), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
